wave_capture_ctrl: RTL
======================

Name: wave_capture_ctrl

Overview:
Capture sequencer for the double-buffered 512x8 sample RAM that the waveform display reads from. It arms on a positive zero crossing of the audio stream and writes 256 consecutive samples into the half the display is not reading. It then waits for the display's idle (blanking) window and flips read_index, so the display never sees a half-written buffer. It sits between the audio sample source and the RAM write port; the display owns the RAM read port.

Parameters:
SAMPLE_W, 16, width of signed two's-complement input samples
DEPTH_LOG2, 8, log2 of samples per half-buffer; RAM address width = DEPTH_LOG2+1
TIMEOUT_SAMPLES, 1024, samples in ARMED before forced trigger (only used with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
new_sample_ready  in  1  single-cycle strobe; new_sample_in valid this cycle
new_sample_in  in  SAMPLE_W  signed audio sample
wave_display_idle  in  1  high while the display is outside the active region (safe to swap)
write_address  out  DEPTH_LOG2+1  RAM write address {~read_index, wr_count}
write_enable  out  1  RAM write strobe
write_sample  out  8  sample converted to unsigned display code
read_index  out  1  half-buffer the display reads; capture always writes the other half

Behaviour:
- Reset (reset=0, asynchronous): state=ARMED, wr_count=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0. Release is synchronous to clk.
- Conversion: write_sample = {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}; this is the top 8 bits with the MSB inverted (offset binary). Examples: 0x8000->0x00, 0x0000->0x80, 0x7FFF->0xFF.
- prev_sample is updated on every new_sample_ready, in all states.
- Positive crossing = prev_sample MSB 1 and new_sample_in MSB 0, on a strobe cycle.
- ARMED: on a positive crossing, write the crossing sample at wr_count=0 in the same cycle. Set wr_count=1 and go to ACTIVE.
- ACTIVE: on each strobe, write at {~read_index, wr_count} and increment wr_count. The write at wr_count=2^DEPTH_LOG2-1 wraps wr_count to 0 and moves to WAIT. Non-strobe cycles leave all state unchanged.
- WAIT: samples are ignored (no writes). When wave_display_idle=1, toggle read_index and go to ARMED, all in one cycle. If idle is already high on WAIT entry, the swap happens on the next clk.
- Output registering: write_enable, write_address and write_sample are registered. They appear one cycle after the strobe, and write_enable is high for exactly 1 cycle per write.
- Exactly 2^DEPTH_LOG2 writes occur per capture.
- A strobe on the same cycle as the ACTIVE->WAIT transition belongs to the last slot only if wr_count=max; otherwise it is written normally.
- Strobes on consecutive cycles are supported, with no throughput limit.
- read_index never changes outside WAIT.
- Reset mid-capture: the partial buffer is abandoned and read_index returns to 0.
- States encoded as 2-bit enum; the unused encoding maps to ARMED.

Optional Feature:
Macro WAVE_CAPTURE_TIMEOUT_EN.
- Defined: an ARMED-state strobe counter forces a trigger on the TIMEOUT_SAMPLES-th strobe without a crossing (that sample written at slot 0). This lets silence or DC still display. The counter clears on leaving ARMED and on reset.
- Undefined: no counter; the block stays in ARMED indefinitely until a crossing occurs.

Decomposition:
- Package wave_pkg holds the state enum (ARMED, ACTIVE, WAIT), the SAMPLE_W/DEPTH_LOG2 defaults, the DISP_W=8 constant and the to_display_code conversion function.
- One sub-module, zero_cross_detect: holds prev_sample and outputs a single-cycle pos_cross pulse on strobe cycles.
- Everything else lives in wave_capture_ctrl.

Test Plan:
- Reset, then strobes with samples 0x1000, 0x2000 (no crossing) -> no write_enable; read_index=0; state ARMED.
- Strobe 0xF000, then 0x0100 -> write_enable 1 cycle later with address 0x100 and write_sample 0x81. Then 255 further strobes write 0x101..0x1FF in order, after which no more writes occur.
- Hold wave_display_idle=0 for 1000 cycles in WAIT with strobes -> zero writes and read_index stays 0. Raise idle -> read_index=1 next cycle; next capture writes addresses 0x000..0x0FF.
- Drive back-to-back strobes every cycle through a full capture -> 256 consecutive write_enable cycles with contiguous addresses.
- Assert reset=0 mid-ACTIVE at wr_count=100 -> all outputs 0 immediately; after release, ARMED, and the next crossing writes at 0x100.
- With WAVE_CAPTURE_TIMEOUT_EN and TIMEOUT_SAMPLES=16, feed constant 0x0400 -> the 16th strobe writes 0x84 at address 0x100. Without the macro, no write occurs after 10000 strobes.

Source files
------------

// File: rtl/wave_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the waveform capture sequencer:
//   - capture state enum (ARMED / ACTIVE / WAIT)
//   - default sample width and half-buffer depth
//   - display code width and the sample-to-display conversion
// ---------------------------------------------------------------------------
package wave_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int DEPTH_LOG2_DEF = 8;
  localparam int DISP_W         = 8;

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    ACTIVE = 2'b01,
    WAIT   = 2'b10
  } wave_state_t;

  // Takes the top DISP_W bits of a signed sample and flips the sign bit,
  // turning two's complement into offset binary (most negative -> 0x00).
  function automatic logic [DISP_W-1:0] to_display_code(input logic [DISP_W-1:0] top_bits);
    return {~top_bits[DISP_W-1], top_bits[DISP_W-2:0]};
  endfunction

endpackage

// File: rtl/wave_capture_ctrl_zero_cross_detect.sv
// ---------------------------------------------------------------------------
// zero_cross_detect
// Flags a positive-going zero crossing of the audio stream: the previous
// sample was negative and the current one is non-negative.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   strobe       in   new sample valid this cycle
//   sample_sign  in   sign bit of the incoming sample
//   pos_cross    out  single-cycle pulse, only on strobe cycles
// ---------------------------------------------------------------------------
module zero_cross_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sample_sign,
  output logic pos_cross
);

  // Only the sign of the previous sample matters for crossing detection,
  // so that is all that is kept; a cleared register reads as sample 0.
  logic prev_sign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sign <= 1'b0;
    end else if (strobe) begin
      prev_sign <= sample_sign;
    end
  end

  assign pos_cross = strobe & prev_sign & ~sample_sign;

endmodule

// File: rtl/wave_capture_ctrl.sv
// ---------------------------------------------------------------------------
// wave_capture_ctrl
// Capture sequencer for a double-buffered sample RAM. Arms on a positive
// zero crossing, writes 2^DEPTH_LOG2 samples into the half the display is
// not reading, then waits for the display idle window before flipping
// read_index.
// Optional feature macro: WAVE_CAPTURE_TIMEOUT_EN -- forces a trigger on the
// TIMEOUT_SAMPLES-th strobe spent in ARMED so silence or DC still displays.
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous active-low reset
//   new_sample_ready   in   single-cycle sample strobe
//   new_sample_in      in   signed audio sample
//   wave_display_idle  in   display is blanking, safe to swap halves
//   write_address      out  RAM write address {~read_index, wr_count}
//   write_enable       out  RAM write strobe (registered)
//   write_sample       out  offset-binary display code (registered)
//   read_index         out  half-buffer currently read by the display
// ---------------------------------------------------------------------------
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int SAMPLE_W        = SAMPLE_W_DEF,
  parameter int DEPTH_LOG2      = DEPTH_LOG2_DEF,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [SAMPLE_W-1:0]   new_sample_in,
  input  logic                  wave_display_idle,
  output logic [DEPTH_LOG2:0]   write_address,
  output logic                  write_enable,
  output logic [DISP_W-1:0]     write_sample,
  output logic                  read_index
);

  localparam logic [DEPTH_LOG2-1:0] LAST_SLOT = '1;

  wave_state_t           state;
  wave_state_t           state_next;
  logic [DEPTH_LOG2-1:0] wr_count;
  logic                  pos_cross;
  logic                  trigger;
  logic                  wr_req;
  logic                  swap_req;
  logic [DEPTH_LOG2:0]   wr_addr_next;

  // Low sample bits are below display resolution.
  logic sample_unused;
  assign sample_unused = ^new_sample_in[SAMPLE_W-DISP_W-1:0];

  zero_cross_detect u_zero_cross (
    .clk         (clk),
    .reset       (reset),
    .strobe      (new_sample_ready),
    .sample_sign (new_sample_in[SAMPLE_W-1]),
    .pos_cross   (pos_cross)
  );

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;

  logic [TO_W-1:0] to_count;
  logic            timeout_hit;

  // Counts strobes seen while armed; the strobe that would make the count
  // reach TIMEOUT_SAMPLES triggers directly and is written at slot 0.
  assign timeout_hit = new_sample_ready && (state == ARMED) &&
                       (to_count == TO_W'(TIMEOUT_SAMPLES - 1));
  assign trigger     = pos_cross | timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_count <= '0;
    end else if ((state != ARMED) || trigger) begin
      to_count <= '0;
    end else if (new_sample_ready) begin
      to_count <= to_count + 1'b1;
    end
  end
`else
  assign trigger = pos_cross;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the spare encoding falls back to ARMED.
  always_comb begin
    state_next = state;
    case (state)
      ARMED:  if (trigger) state_next = ACTIVE;
      ACTIVE: if (new_sample_ready && (wr_count == LAST_SLOT)) state_next = WAIT;
      WAIT:   if (wave_display_idle) state_next = ARMED;
      default: state_next = ARMED;
    endcase
  end

  // Per-state actions: which cycles write a sample and when the halves swap.
  always_comb begin
    wr_req   = 1'b0;
    swap_req = 1'b0;
    case (state)
      ARMED:  wr_req   = trigger;
      ACTIVE: wr_req   = new_sample_ready;
      WAIT:   swap_req = wave_display_idle;
      default: ;
    endcase
  end

  // wr_count is zero whenever ARMED, so the trigger sample lands at slot 0.
  assign wr_addr_next = {~read_index, wr_count};

  // Datapath and registered RAM write port. wr_count wraps naturally after
  // the last slot, leaving it at zero for the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count      <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      if (wr_req) begin
        wr_count      <= wr_count + 1'b1;
        write_address <= wr_addr_next;
        write_sample  <= to_display_code(new_sample_in[SAMPLE_W-1 -: DISP_W]);
      end
      if (swap_req) begin
        read_index <= ~read_index;
      end
      write_enable <= wr_req;
    end
  end

endmodule
